// File: rtl/io_map_pkg.sv
// Address map and helpers shared by the miniRV I/O bridge.
package io_map_pkg;

    localparam int unsigned DATA_W = 32;

    localparam logic [19:0] IO_BASE = 20'hFFFFF;

    localparam logic [11:0] OFF_DISP  = 12'h000;
    localparam logic [11:0] OFF_TIMER = 12'h020;
    localparam logic [11:0] OFF_TDIV  = 12'h024;
    localparam logic [11:0] OFF_LED   = 12'h060;
    localparam logic [11:0] OFF_SW    = 12'h070;

    // Replace the bytes of old_word selected by mask with those of new_word.
    function automatic logic [DATA_W-1:0] byte_merge(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] new_word,
        input logic [3:0]        mask
    );
        logic [DATA_W-1:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/sw_debounce.sv
// Two-flop synchronizer followed by a stability counter; the output only
// follows the input after it has held still for DEBOUNCE_CYCLES cycles.
module sw_debounce #(
    parameter int unsigned WIDTH           = 24,
    parameter int unsigned DEBOUNCE_CYCLES = 200000
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_stable
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sw_meta;
    logic [WIDTH-1:0] sw_sync;
    logic [WIDTH-1:0] sw_prev;
    logic [CNT_W-1:0] cnt;
    logic             same;

    assign same = (sw_sync == sw_prev);

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            sw_meta   <= '0;
            sw_sync   <= '0;
            sw_prev   <= '0;
            cnt       <= '0;
            sw_stable <= '0;
        end else begin
            sw_meta <= sw_raw;
            sw_sync <= sw_meta;
            sw_prev <= sw_sync;
            if (!same) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + CNT_W'(1);
            end
            // A change arriving while saturated must not slip through.
            if (same && (cnt == CNT_MAX)) begin
                sw_stable <= sw_sync;
            end
        end
    end

endmodule

// File: rtl/io_bridge.sv
// Memory-mapped I/O bridge for the miniRV data port: display, LED, debounced
// switches and a prescaled timer, with a single-cycle combinational read path.
module io_bridge
    import io_map_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 200000,
    parameter int unsigned TIMER_DIV_RST   = 100000
) (
    input  logic        clk_i,
    input  logic        rst_n,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  wmask_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        sel_o,
    input  logic [23:0] device_sw,
    output logic [31:0] display_number,
    output logic [23:0] led_o
);

    logic [11:0] off;
    logic        wr;
    logic        wr_disp;
    logic        wr_timer;
    logic        wr_tdiv;
    logic        wr_led;
    logic [31:0] timer_q;
    logic [31:0] tdiv_q;
    logic [31:0] pre_q;
    logic        tick;
    logic [23:0] sw_stable;

    sw_debounce #(
        .WIDTH           (24),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_sw_debounce (
        .clk_i     (clk_i),
        .rst_n     (rst_n),
        .sw_raw    (device_sw),
        .sw_stable (sw_stable)
    );

    // Decode: word offset within the 4 KiB window.
    assign sel_o    = (addr_i[31:12] == IO_BASE);
    assign off      = addr_i[11:0] & 12'hFFC;
    assign wr       = we_i && sel_o;
    assign wr_disp  = wr && (off == OFF_DISP);
    assign wr_timer = wr && (off == OFF_TIMER);
    assign wr_tdiv  = wr && (off == OFF_TDIV);
    assign wr_led   = wr && (off == OFF_LED);

    assign tick = (tdiv_q != 32'd0) && (pre_q == tdiv_q - 32'd1);

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            display_number <= '0;
            led_o          <= '0;
        end else begin
            if (wr_disp) begin
                display_number <= byte_merge(display_number, wdata_i, wmask_i);
            end
            if (wr_led) begin
                led_o <= 24'(byte_merge({8'h00, led_o}, wdata_i, wmask_i));
            end
        end
    end

    // Prescaler and timer; an explicit TIMER write overrides a coincident tick.
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            timer_q <= '0;
            tdiv_q  <= 32'(TIMER_DIV_RST);
            pre_q   <= '0;
        end else begin
            if (wr_tdiv) begin
                tdiv_q <= byte_merge(tdiv_q, wdata_i, wmask_i);
            end
            if (wr_timer || wr_tdiv || (tdiv_q == 32'd0) || tick) begin
                pre_q <= '0;
            end else begin
                pre_q <= pre_q + 32'd1;
            end
            if (wr_timer) begin
                timer_q <= byte_merge(timer_q, wdata_i, wmask_i);
            end else if (tick) begin
                timer_q <= timer_q + 32'd1;
            end
        end
    end

    always_comb begin
        rdata_o = '0;
        if (sel_o) begin
            case (off)
                OFF_DISP:  rdata_o = display_number;
                OFF_TIMER: rdata_o = timer_q;
                OFF_TDIV:  rdata_o = tdiv_q;
                OFF_LED:   rdata_o = {8'h00, led_o};
                OFF_SW:    rdata_o = {8'h00, sw_stable};
                default:   rdata_o = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_io_bridge.sv
// Directed bench for io_bridge with a short debounce window and prescaler.
module tb_io_bridge;

    logic        clk_i;
    logic        rst_n;
    logic [31:0] addr_i;
    logic        we_i;
    logic [3:0]  wmask_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;
    logic        sel_o;
    logic [23:0] device_sw;
    logic [31:0] display_number;
    logic [23:0] led_o;

    int tests_run    = 0;
    int tests_failed = 0;

    io_bridge #(
        .DEBOUNCE_CYCLES (4),
        .TIMER_DIV_RST   (3)
    ) dut (
        .clk_i          (clk_i),
        .rst_n          (rst_n),
        .addr_i         (addr_i),
        .we_i           (we_i),
        .wmask_i        (wmask_i),
        .wdata_i        (wdata_i),
        .rdata_o        (rdata_o),
        .sel_o          (sel_o),
        .device_sw      (device_sw),
        .display_number (display_number),
        .led_o          (led_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // One store cycle, driven between negedges so the posedge samples it.
    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        addr_i  = a;
        wdata_i = d;
        wmask_i = m;
        we_i    = 1'b1;
        @(negedge clk_i);
        we_i    = 1'b0;
        wmask_i = 4'h0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        addr_i = a;
        we_i   = 1'b0;
        #1;
        d = rdata_o;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst_n = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_n = 1'b1;
        tests_run++;
        if (display_number !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_disp: got %h want %h", display_number, 32'h0);
        end
        tests_run++;
        if (led_o !== 24'h0) begin
            tests_failed++;
            $display("FAIL reset_led: got %h want %h", led_o, 24'h0);
        end
        rd(32'hFFFFF020, d);
        tests_run++;
        if (d !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_timer: got %h want %h", d, 32'h0);
        end
        rd(32'hFFFFF024, d);
        tests_run++;
        if (d !== 32'h3) begin
            tests_failed++;
            $display("FAIL reset_tdiv: got %h want %h", d, 32'h3);
        end
        rd(32'hFFFFF070, d);
        tests_run++;
        if (d !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_sw: got %h want %h", d, 32'h0);
        end
    endtask

    task automatic test_byte_store();
        logic [31:0] d;
        wr(32'hFFFFF000, 32'h12345678, 4'hF);
        tests_run++;
        if (display_number !== 32'h12345678) begin
            tests_failed++;
            $display("FAIL disp_full: got %h want %h", display_number, 32'h12345678);
        end
        wr(32'hFFFFF000, 32'hAABBCCDD, 4'h5);
        tests_run++;
        if (display_number !== 32'h12BB56DD) begin
            tests_failed++;
            $display("FAIL disp_mask5: got %h want %h", display_number, 32'h12BB56DD);
        end
        wr(32'hFFFFF000, 32'hFFFFFFFF, 4'h0);
        rd(32'hFFFFF000, d);
        tests_run++;
        if (d !== 32'h12BB56DD) begin
            tests_failed++;
            $display("FAIL disp_mask0: got %h want %h", d, 32'h12BB56DD);
        end
        wr(32'hFFFFF060, 32'hFFFFFFFF, 4'hF);
        tests_run++;
        if (led_o !== 24'hFFFFFF) begin
            tests_failed++;
            $display("FAIL led_out: got %h want %h", led_o, 24'hFFFFFF);
        end
        rd(32'hFFFFF060, d);
        tests_run++;
        if (d !== 32'h00FFFFFF) begin
            tests_failed++;
            $display("FAIL led_read: got %h want %h", d, 32'h00FFFFFF);
        end
    endtask

    task automatic test_debounce();
        logic [31:0] d;
        for (int i = 0; i < 10; i++) begin
            device_sw = (i % 2 == 0) ? 24'h00000F : 24'h000000;
            for (int j = 0; j < 2; j++) begin
                @(negedge clk_i);
                rd(32'hFFFFF070, d);
                tests_run++;
                if (d !== 32'h0) begin
                    tests_failed++;
                    $display("FAIL sw_bounce[%0d]: got %h want %h", i, d, 32'h0);
                end
            end
        end
        device_sw = 24'h00A5A5;
        repeat (5) @(negedge clk_i);
        rd(32'hFFFFF070, d);
        tests_run++;
        if (d !== 32'h0) begin
            tests_failed++;
            $display("FAIL sw_early: got %h want %h", d, 32'h0);
        end
        repeat (2) @(negedge clk_i);
        rd(32'hFFFFF070, d);
        tests_run++;
        if (d !== 32'h00A5A5) begin
            tests_failed++;
            $display("FAIL sw_settled: got %h want %h", d, 32'h00A5A5);
        end
    endtask

    task automatic test_timer();
        logic [31:0] d;
        wr(32'hFFFFF020, 32'h0, 4'hF);
        wr(32'hFFFFF024, 32'h3, 4'hF);
        repeat (11) @(negedge clk_i);
        rd(32'hFFFFF020, d);
        tests_run++;
        if (d !== 32'd3) begin
            tests_failed++;
            $display("FAIL timer_11: got %h want %h", d, 32'd3);
        end
        @(negedge clk_i);
        rd(32'hFFFFF020, d);
        tests_run++;
        if (d !== 32'd4) begin
            tests_failed++;
            $display("FAIL timer_12: got %h want %h", d, 32'd4);
        end
        wr(32'hFFFFF020, 32'hFFFFFFFF, 4'hF);
        repeat (2) @(negedge clk_i);
        rd(32'hFFFFF020, d);
        tests_run++;
        if (d !== 32'hFFFFFFFF) begin
            tests_failed++;
            $display("FAIL timer_prewrap: got %h want %h", d, 32'hFFFFFFFF);
        end
        @(negedge clk_i);
        rd(32'hFFFFF020, d);
        tests_run++;
        if (d !== 32'h0) begin
            tests_failed++;
            $display("FAIL timer_wrap: got %h want %h", d, 32'h0);
        end
        // Two idle cycles put the next write on the edge of the following tick.
        repeat (2) @(negedge clk_i);
        wr(32'hFFFFF020, 32'd7, 4'hF);
        rd(32'hFFFFF020, d);
        tests_run++;
        if (d !== 32'd7) begin
            tests_failed++;
            $display("FAIL timer_write_on_tick: got %h want %h", d, 32'd7);
        end
        repeat (3) @(negedge clk_i);
        rd(32'hFFFFF020, d);
        tests_run++;
        if (d !== 32'd8) begin
            tests_failed++;
            $display("FAIL timer_after_write: got %h want %h", d, 32'd8);
        end
        wr(32'hFFFFF024, 32'h0, 4'hF);
        repeat (20) @(negedge clk_i);
        rd(32'hFFFFF020, d);
        tests_run++;
        if (d !== 32'd8) begin
            tests_failed++;
            $display("FAIL timer_stopped: got %h want %h", d, 32'd8);
        end
    endtask

    task automatic test_decode();
        logic [31:0] d;
        wr(32'hFFFFF070, 32'h00FFFFFF, 4'hF);
        rd(32'hFFFFF070, d);
        tests_run++;
        if (d !== 32'h00A5A5) begin
            tests_failed++;
            $display("FAIL sw_write_ignored: got %h want %h", d, 32'h00A5A5);
        end
        wr(32'hFFFFF100, 32'hDEADBEEF, 4'hF);
        tests_run++;
        if (display_number !== 32'h12BB56DD) begin
            tests_failed++;
            $display("FAIL unmapped_disp: got %h want %h", display_number, 32'h12BB56DD);
        end
        tests_run++;
        if (led_o !== 24'hFFFFFF) begin
            tests_failed++;
            $display("FAIL unmapped_led: got %h want %h", led_o, 24'hFFFFFF);
        end
        rd(32'hFFFFF024, d);
        tests_run++;
        if (d !== 32'h0) begin
            tests_failed++;
            $display("FAIL unmapped_tdiv: got %h want %h", d, 32'h0);
        end
        rd(32'hFFFFF100, d);
        tests_run++;
        if (d !== 32'h0) begin
            tests_failed++;
            $display("FAIL unmapped_read: got %h want %h", d, 32'h0);
        end
        tests_run++;
        if (sel_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL sel_in_window: got %b want %b", sel_o, 1'b1);
        end
        addr_i  = 32'h00001000;
        wdata_i = 32'h0;
        wmask_i = 4'hF;
        we_i    = 1'b1;
        #1;
        tests_run++;
        if (sel_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL sel_outside: got %b want %b", sel_o, 1'b0);
        end
        @(negedge clk_i);
        we_i = 1'b0;
        tests_run++;
        if (display_number !== 32'h12BB56DD) begin
            tests_failed++;
            $display("FAIL outside_write: got %h want %h", display_number, 32'h12BB56DD);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        addr_i    = 32'h0;
        we_i      = 1'b0;
        wmask_i   = 4'h0;
        wdata_i   = 32'h0;
        device_sw = 24'h0;
        @(negedge clk_i);
        test_reset();
        test_byte_store();
        test_debounce();
        test_timer();
        test_decode();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/io_bridge.md
# io_bridge

Memory-mapped peripheral bridge between the miniRV core's data-memory port and the board I/O. It decodes CPU loads and stores in the I/O window, and holds the register that drives `display_number` into `led_display`. It also owns the LED register, a synchronized and debounced copy of `device_sw`, and a prescaled free-running timer, so that firmware sees stable switch values and a time base.

## Interface
One clock; reset is synchronous and active-low. Clock port is `clk_i`; reset port is `rst_n`.

Parameters:
- `DEBOUNCE_CYCLES`, 200000: consecutive stable cycles required before a switch change is accepted; must be ≥ 2.
- `TIMER_DIV_RST`, 100000: reset value of the timer divider register.

Ports:
- `clk_i`  in  1: system clock.
- `rst_n`  in  1: synchronous active-low reset.
- `addr_i`  in  32: CPU data address.
- `we_i`  in  1: store strobe; valid in the same cycle as `addr_i`.
- `wmask_i`  in  4: byte enables; bit n enables `wdata_i[8n+7:8n]`.
- `wdata_i`  in  32: store data.
- `rdata_o`  out  32: load data; combinational from `addr_i` and registered state.
- `sel_o`  out  1: `addr_i[31:12] == 20'hFFFFF`; the CPU uses it to select `rdata_o` over DRAM and to suppress the DRAM write.
- `device_sw`  in  24: raw asynchronous board switches.
- `display_number`  out  32: registered value consumed by `led_display`.
- `led_o`  out  24: registered LED register.

## Operation
Address map (offset = `addr_i[11:0]`, word aligned; `addr_i[1:0]` ignored):
- 0x000 DISP, R/W, 32 bits: drives `display_number`.
- 0x020 TIMER, R/W, 32 bits: current timer count.
- 0x024 TDIV, R/W, 32 bits: prescaler terminal count.
- 0x060 LED, R/W, 24 bits: drives `led_o`; `wdata_i[31:24]` is ignored and reads return 0 in [31:24].
- 0x070 SW, R only: `{8'h0, sw_stable}`; writes are ignored.
- Any other offset: reads return 0; writes are ignored.

Write behaviour:
- A write happens on a rising edge when `we_i && sel_o`.
- Only the bytes with their `wmask_i` bit set are updated.
- `wmask_i == 0` changes nothing.

Switch path:
- `device_sw` passes through a 2-FF synchronizer to give `sw_sync`.
- A counter `cnt` clears whenever `sw_sync != sw_prev`, and otherwise increments, saturating.
- When `cnt == DEBOUNCE_CYCLES-1`, `sw_stable <= sw_sync`.
- Any change restarts the count. Bouncing faster than the window never updates `sw_stable`.

Timer:
- A prescaler counts 0..TDIV-1. On reaching TDIV-1 it wraps to 0 and TIMER increments.
- TIMER wraps from 0xFFFF_FFFF to 0.
- TDIV == 0 stops the timer: the prescaler is held at 0 and TIMER holds.
- A write to TIMER (any byte) clears the prescaler.
- If a TIMER write and a tick coincide, the written value wins and no increment is applied.
- A write to TDIV clears the prescaler.

Reset values (all clear when `rst_n == 0` at an edge):
- DISP = 0, LED = 0, TIMER = 0, TDIV = `TIMER_DIV_RST`.
- Prescaler = 0, synchronizer FFs = 0, `sw_prev` = 0, `cnt` = 0, `sw_stable` = 0.
- Reset asserted mid-debounce or mid-prescale discards the partial count.

## Timing
- Store: the register updates at the edge where `we_i` is sampled. `display_number` and `led_o` show the new value 1 cycle after the store cycle.
- Load: `rdata_o` is valid in the same cycle as `addr_i`, with no wait states, as required by the single-cycle core. A load following a store in the next cycle returns the stored value.
- Switch latency: a clean change on `device_sw` appears in `sw_stable` `2 + DEBOUNCE_CYCLES` cycles later, ±1.
- Timer: with TDIV = N, TIMER increments once every N cycles. The first increment after a TDIV write comes N cycles after that write edge.
- `sel_o` and `rdata_o` have no registered stage; they are purely combinational.

## Structure
- Package `io_map_pkg`:
  - window base `20'hFFFFF`;
  - offset constants `OFF_DISP`, `OFF_TIMER`, `OFF_TDIV`, `OFF_LED`, `OFF_SW`;
  - the byte-mask merge function (old, new, mask → merged word).
- Sub-module `sw_debounce`:
  - parameters: width, `DEBOUNCE_CYCLES`;
  - contents: synchronizer plus stability counter;
  - ports: `clk_i`, `rst_n`, raw in, stable out.
- `io_bridge` holds the decoder, the registers, the prescaler/timer, and the read mux.

## Test plan
Run with `DEBOUNCE_CYCLES = 4` and `TIMER_DIV_RST = 3`.
- **Reset:** hold `rst_n = 0` for 2 cycles → `display_number` = 0, `led_o` = 0, read 0x020 = 0, read 0x024 = 3, read 0x070 = 0.
- **Byte-masked store:**
  - write 0xFFFFF000 = 0x12345678 with mask 0xF, then 0xFFFFF000 = 0xAABBCCDD with mask 0x5 → `display_number` = 0x12BB56DD;
  - write 0xFFFFF060 = 0xFFFFFFFF → `led_o` = 0xFFFFFF and readback = 0x00FFFFFF.
- **Debounce:**
  - `device_sw` toggles 0↔0x00000F every 2 cycles for 20 cycles → SW reads 0 throughout;
  - then hold 0x00A5A5 → SW reads 0x00A5A5 within 6–7 cycles.
- **Timer:**
  - TDIV = 3 → TIMER = 4 after 12 cycles;
  - write TIMER = 0xFFFFFFFF → it wraps to 0 after 3 cycles;
  - write TIMER = 7 on a tick edge → reads 7;
  - write TDIV = 0 → TIMER holds for 20 cycles.
- **Decode:**
  - store to 0xFFFFF070 or 0xFFFFF100 → no state change;
  - read 0xFFFFF100 → 0;
  - address 0x00001000 → `sel_o` = 0 and no register changes despite `we_i = 1`.
